// File: rtl/datapath_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_ctrl
//  Purpose  : Instruction register plus Moore-style control FSM that sequences
//             register-file reads/writes, A/B/C/status loads, shifter and ALU
//             controls for a simple 16-bit datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module datapath_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_CALC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    // Instruction fields
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    // Instruction class decode
    logic w_mov_imm;
    logic w_mov_reg;
    logic w_mvn;
    logic w_alu_ab;
    logic w_cmp;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_mvn     = (w_opcode == 3'b101) && (w_op == 2'b11);
    // ADD, CMP and AND all need both operands fetched
    assign w_alu_ab  = (w_opcode == 3'b101) && (w_op != 2'b11);
    assign w_cmp     = (w_opcode == 3'b101) && (w_op == 2'b01);

    // Immediate is always presented sign-extended, independent of state
    assign datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};

    // Instruction register: loads only while idle so a running instruction
    // always sees a stable encoding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= 16'h0000;
        end else if ((r_state == S_WAIT) && load) begin
            r_ir <= in;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; every output defaults to its idle value
    always_comb begin
        w_next   = r_state;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;

        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_mov_imm) begin
                    w_next = S_WRITE_IMM;
                end else if (w_mov_reg || w_mvn) begin
                    w_next = S_GET_B;
                end else if (w_alu_ab) begin
                    w_next = S_GET_A;
                end else begin
                    // Unsupported encoding: drop back to idle silently
                    w_next = S_WAIT;
                end
            end
            S_WRITE_IMM: begin
                write    = 1'b1;
                vsel     = 1'b1;
                writenum = w_rn;
                w_next   = S_WAIT;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = S_GET_B;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = S_CALC;
            end
            S_CALC: begin
                shift = w_sh;
                bsel  = 1'b1;
                // MOV reg reuses the ADD path with a zeroed A operand
                ALUop = w_mov_reg ? 2'b00 : w_op;
                asel  = !(w_mov_reg || w_mvn);
                if (w_cmp) begin
                    loads  = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                vsel     = 1'b0;
                writenum = w_rd;
                w_next   = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_ctrl
//  Purpose  : Directed self-checking bench for datapath_ctrl with
//             hand-computed control vectors per FSM cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_ctrl;

    logic        clk;
    logic        reset_n;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] datapath_in;

    int n_total;
    int n_pass;

    datapath_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s           (s),
        .load        (load),
        .in          (in),
        .w           (w),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .datapath_in (datapath_in)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All control outputs packed for single-shot comparison
    logic [18:0] ctrl;
    assign ctrl = {w, readnum, writenum, write, vsel, loada, loadb,
                   loadc, loads, asel, bsel, shift, ALUop};

    function automatic logic [18:0] mk(
        input logic       ww,
        input logic [2:0] rn,
        input logic [2:0] wn,
        input logic       wr,
        input logic       vs,
        input logic       la,
        input logic       lb,
        input logic       lc,
        input logic       ls,
        input logic       as,
        input logic       bs,
        input logic [1:0] sh,
        input logic [1:0] op
    );
        return {ww, rn, wn, wr, vs, la, lb, lc, ls, as, bs, sh, op};
    endfunction

    localparam logic [18:0] C_IDLE = 19'h40000;  // only w set
    localparam logic [18:0] C_BUSY = 19'h00000;  // DECODE: nothing set

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a word and pulse s on the same WAIT edge; returns in DECODE
    task automatic start(input logic [15:0] word);
        in   = word;
        load = 1'b1;
        s    = 1'b1;
        step();
        load = 1'b0;
        s    = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        s       = 1'b0;
        load    = 1'b0;
        in      = 16'h0000;

        // Reset state
        #2;
        chk("reset_ctrl", {13'd0, ctrl}, {13'd0, C_IDLE});
        chk("reset_imm", {16'd0, datapath_in}, 32'h0000);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        chk("post_reset_idle", {13'd0, ctrl}, {13'd0, C_IDLE});

        // Load without s: IR updates, FSM stays idle
        in   = 16'h0080;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("load_only_ctrl", {13'd0, ctrl}, {13'd0, C_IDLE});
        chk("load_only_imm", {16'd0, datapath_in}, 32'hFF80);

        // MOV R2,#-5
        start(16'hD2FB);
        chk("movi_decode", {13'd0, ctrl}, {13'd0, C_BUSY});
        chk("movi_imm", {16'd0, datapath_in}, 32'hFFFB);
        step();
        chk("movi_write", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("movi_done", {13'd0, ctrl}, {13'd0, C_IDLE});

        // ADD R3,R1,R0 LSL#1 with s/load hammered while busy
        start(16'hA168);
        chk("add_decode", {13'd0, ctrl}, {13'd0, C_BUSY});
        in   = 16'hE0FF;
        load = 1'b1;
        s    = 1'b1;
        step();
        chk("add_get_a", {13'd0, ctrl},
            {13'd0, mk(0, 3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        chk("add_ir_held", {16'd0, datapath_in}, 32'h0068);
        step();
        chk("add_get_b", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("add_calc", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b01, 2'b00)});
        step();
        chk("add_write_reg", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        load = 1'b0;
        s    = 1'b0;
        step();
        chk("add_done", {13'd0, ctrl}, {13'd0, C_IDLE});
        chk("add_ir_final", {16'd0, datapath_in}, 32'h0068);

        // CMP R1,R0
        start(16'hA900);
        step();
        chk("cmp_get_a", {13'd0, ctrl},
            {13'd0, mk(0, 3'd1, 3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("cmp_get_b", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("cmp_calc", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b01)});
        step();
        chk("cmp_done", {13'd0, ctrl}, {13'd0, C_IDLE});

        // MOV R7,R1
        start(16'hC0E1);
        step();
        chk("movr_get_b", {13'd0, ctrl},
            {13'd0, mk(0, 3'd1, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("movr_calc", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00)});
        step();
        chk("movr_write_reg", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("movr_done", {13'd0, ctrl}, {13'd0, C_IDLE});

        // MVN R2,R2 LSL#1
        start(16'hB84A);
        step();
        chk("mvn_get_b", {13'd0, ctrl},
            {13'd0, mk(0, 3'd2, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("mvn_calc", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 2'b11)});
        step();
        chk("mvn_write_reg", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        chk("mvn_done", {13'd0, ctrl}, {13'd0, C_IDLE});

        // Illegal opcode 111
        start(16'hE000);
        chk("ill_decode", {13'd0, ctrl}, {13'd0, C_BUSY});
        chk("ill_imm", {16'd0, datapath_in}, 32'h0000);
        step();
        chk("ill_done", {13'd0, ctrl}, {13'd0, C_IDLE});

        // Illegal op field under opcode 110
        start(16'hC900);
        step();
        chk("ill2_done", {13'd0, ctrl}, {13'd0, C_IDLE});

        // Reset asserted during CALC of an ADD
        start(16'hA168);
        step();
        step();
        step();
        chk("rst_pre_calc", {13'd0, ctrl},
            {13'd0, mk(0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b01, 2'b00)});
        #3 reset_n = 1'b0;
        #1;
        chk("rst_async_ctrl", {13'd0, ctrl}, {13'd0, C_IDLE});
        chk("rst_async_ir", {16'd0, datapath_in}, 32'h0000);
        step();
        chk("rst_no_write_reg", {13'd0, ctrl}, {13'd0, C_IDLE});
        #2 reset_n = 1'b1;
        step();
        chk("rst_release_idle", {13'd0, ctrl}, {13'd0, C_IDLE});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
